// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, types and helpers
// Purpose : constants and types shared by the fetch unit and its buffers.
// Contents: ILEN, NOP_INSTR, RESET_PC_DEFAULT, ibuf_entry_t, word_align().
package cpu_pkg;

  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One instruction buffer slot: the fetched word and the address it came from.
  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ibuf_entry_t;

  function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] addr);
    return {addr[ILEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush and occupancy count
// Purpose : single-clock FIFO; head entry is read straight from storage.
// Ports   : clk_i, rst_i (sync, active-high), flush_i (empty the FIFO),
//           push_i/push_data_i, pop_i/pop_data_o, full_o, empty_o, count_o.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: fetch PC, imem requests, IF/ID output buffer
// Purpose : owns the fetch PC, issues in-order word requests on a req/gnt +
//           rvalid bus, pairs each returned word with its PC and presents it
//           to IF/ID; honours stall and EX redirects, dropping wrong-path data.
// Ports   : clk, rst (sync, active-high)
//           stall_IF, redirect, redirect_PC          - pipeline control
//           imem_req/imem_addr/imem_gnt              - request channel
//           imem_rvalid/imem_rdata                   - in-order response channel
//           valid_IF, instr_IF, PC_IF, PCPlus4_IF    - IF/ID output
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_IF,
  input  logic        redirect,
  input  logic [31:0] redirect_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_IF,
  output logic [31:0] instr_IF,
  output logic [31:0] PC_IF,
  output logic [31:0] PCPlus4_IF
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          fire, rsp_drop, rsp_keep, ibuf_push, ibuf_pop;
  logic [CW:0]   credit_used;

  logic [31:0]   pcq_head;
  logic          pcq_full, pcq_empty;
  logic [CW-1:0] pcq_count;

  ibuf_entry_t   ibuf_in, ibuf_head;
  logic          ibuf_full, ibuf_empty;
  logic [CW-1:0] ibuf_count;

  // Every in-flight request and every buffered word holds one credit, so
  // neither queue can overflow however long the consumer stalls.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, ibuf_count};
  assign imem_req    = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;

  assign fire      = imem_req && imem_gnt;
  assign rsp_drop  = imem_rvalid && (drop_q != '0);
  assign rsp_keep  = imem_rvalid && (drop_q == '0);
  assign ibuf_push = rsp_keep && !redirect;
  assign ibuf_pop  = valid_IF && !stall_IF;
  assign ibuf_in   = '{pc: pcq_head, instr: imem_rdata};

  always_comb begin
    fetch_pc_d    = fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rvalid);
    drop_d        = drop_q - CW'(rsp_drop);
    if (redirect) begin
      fetch_pc_d = word_align(redirect_PC);
      // Everything still in flight after this cycle belongs to the old path.
      drop_d     = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      // Reset cannot cancel requests already granted on the bus, so the
      // in-flight count survives and all of it is marked for discard.
      outstanding_q <= outstanding_d;
      drop_q        <= outstanding_d;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // PC of every live (non-dropped) request, in issue order.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect),
    .push_i      (fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (rsp_keep),
    .pop_data_o  (pcq_head),
    .full_o      (pcq_full),
    .empty_o     (pcq_empty),
    .count_o     (pcq_count)
  );

  // Returned words waiting for IF/ID; the head drives the outputs directly.
  sync_fifo #(
    .WIDTH ($bits(ibuf_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect),
    .push_i      (ibuf_push),
    .push_data_i (ibuf_in),
    .pop_i       (ibuf_pop),
    .pop_data_o  (ibuf_head),
    .full_o      (ibuf_full),
    .empty_o     (ibuf_empty),
    .count_o     (ibuf_count)
  );

  assign valid_IF   = !ibuf_empty;
  assign instr_IF   = valid_IF ? ibuf_head.instr : NOP_INSTR;
  assign PC_IF      = valid_IF ? ibuf_head.pc    : 32'h0000_0000;
  assign PCPlus4_IF = PC_IF + 32'd4;

  always_ff @(posedge clk) begin
    if (imem_rvalid)
      assert (outstanding_q != '0) else $error("imem_rvalid with no request outstanding");
    if (!rst) begin
      assert (outstanding_q <= CW'(DEPTH)) else $error("outstanding exceeds DEPTH");
      assert (pcq_count == outstanding_q - drop_q) else $error("PC queue out of step with live requests");
      if (fire)      assert (!pcq_full)  else $error("PC queue overflow");
      if (rsp_keep)  assert (!pcq_empty) else $error("response with no PC queued");
      if (ibuf_push) assert (!ibuf_full) else $error("instruction buffer overflow");
    end
  end

endmodule
